x86_insn_prefix_decoder: RTL

- Byte-serial front end of the x86-64 decode path; sits between the fetch byte queue and the opcode/operand decode stage.
- Consumes legacy prefixes, REX, the one-byte or 0F-escaped opcode, ModRM, SIB and displacement.
- Emits one decoded header record per instruction over a valid/ready handshake.
- Immediates are not consumed; downstream sizes them from opcode and prefixes.

---
 rtl/x86_insn_prefix_decoder.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/x86_insn_prefix_decoder.sv
// Byte-serial x86-64 instruction header decoder: prefixes, REX, opcode, ModRM, SIB, displacement.
// Define X86_REX_EN to treat 40-4F as REX prefixes; otherwise they decode as one-byte opcodes.
module x86_insn_prefix_decoder #(
    parameter int           MAX_PFX    = 4,
    parameter logic [255:0] MODRM_MAP1 = 256'hC0C0_0000_FF0F_00F3_0000_0000_0000_FFFF_0000_0A0C_0000_0000_0F0F_0F0F_0F0F_0F0F,
    parameter logic [255:0] MODRM_MAP2 = 256'hFFFF_FFFF_FFFF_00FF_FFFF_F838_FFFF_0000_FF7F_FFFF_FFFF_FFFF_0000_FF0F_FFFF_200F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_pfx,
    output logic        out_seg_vld,
    output logic [2:0]  out_seg,
    output logic        out_rex_vld,
    output logic [3:0]  out_rex,
    output logic        out_esc,
    output logic [7:0]  out_opcode,
    output logic        out_has_modrm,
    output logic [7:0]  out_modrm,
    output logic        out_has_sib,
    output logic [7:0]  out_sib,
    output logic [2:0]  out_disp_len,
    output logic [31:0] out_disp,
    output logic [3:0]  out_len,
    output logic        out_err
);

    typedef enum logic [2:0] {S_PFX, S_ESC, S_MODRM, S_SIB, S_DISP} state_t;

    typedef struct packed {
        logic [4:0]  pfx;
        logic        seg_vld;
        logic [2:0]  seg;
        logic        rex_vld;
        logic [3:0]  rex;
        logic        esc;
        logic [7:0]  opcode;
        logic        has_modrm;
        logic [7:0]  modrm;
        logic        has_sib;
        logic [7:0]  sib;
        logic [2:0]  disp_len;
        logic [31:0] disp;
        logic [3:0]  len;
        logic        err;
    } rec_t;

    localparam logic [2:0] PFX_LIM = 3'(MAX_PFX);

    state_t     state_q, state_d;
    rec_t       rec_q, rec_d;
    rec_t       out_q, out_d;
    logic       out_valid_q, out_valid_d;
    logic [2:0] pfx_cnt_q, pfx_cnt_d;
    logic [2:0] disp_cnt_q, disp_cnt_d;
    logic [2:0] dl;
    logic       accept;
    logic       done;

    function automatic logic is_legacy(input logic [7:0] b);
        case (b)
            8'hF0, 8'hF2, 8'hF3, 8'h66, 8'h67,
            8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: is_legacy = 1'b1;
            default:                                  is_legacy = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] seg_code(input logic [7:0] b);
        case (b)
            8'h26:   seg_code = 3'd0;
            8'h2E:   seg_code = 3'd1;
            8'h36:   seg_code = 3'd2;
            8'h3E:   seg_code = 3'd3;
            8'h64:   seg_code = 3'd4;
            default: seg_code = 3'd5;
        endcase
    endfunction

    // base5 is rm==101 when called from ModRM, SIB.base==101 when called from SIB
    function automatic logic [2:0] disp_len_f(input logic [1:0] md, input logic base5);
        case (md)
            2'b01:   disp_len_f = 3'd1;
            2'b10:   disp_len_f = 3'd4;
            2'b00:   disp_len_f = base5 ? 3'd4 : 3'd0;
            default: disp_len_f = 3'd0;
        endcase
    endfunction

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        rec_d       = rec_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        pfx_cnt_d   = pfx_cnt_q;
        disp_cnt_d  = disp_cnt_q;
        dl          = 3'd0;
        done        = 1'b0;
        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;
        if (accept) begin
            rec_d.len = rec_q.len + 4'd1;
            case (state_q)
                S_PFX: begin
                    if (is_legacy(in_byte)) begin
                        if (pfx_cnt_q == PFX_LIM) begin
                            rec_d.err    = 1'b1;
                            rec_d.opcode = in_byte;
                            done         = 1'b1;
                        end else begin
                            pfx_cnt_d     = pfx_cnt_q + 3'd1;
                            rec_d.rex_vld = 1'b0;
                            rec_d.rex     = 4'd0;
                            case (in_byte)
                                8'hF0:   rec_d.pfx[4] = 1'b1;
                                8'hF2:   rec_d.pfx[3] = 1'b1;
                                8'hF3:   rec_d.pfx[2] = 1'b1;
                                8'h66:   rec_d.pfx[1] = 1'b1;
                                8'h67:   rec_d.pfx[0] = 1'b1;
                                default: begin
                                    rec_d.seg_vld = 1'b1;
                                    rec_d.seg     = seg_code(in_byte);
                                end
                            endcase
                        end
                    end
`ifdef X86_REX_EN
                    else if (in_byte[7:4] == 4'h4) begin
                        rec_d.rex_vld = 1'b1;
                        rec_d.rex     = in_byte[3:0];
                    end
`endif
                    else if (in_byte == 8'h0F) begin
                        rec_d.esc = 1'b1;
                        state_d   = S_ESC;
                    end else begin
                        rec_d.opcode = in_byte;
                        if (MODRM_MAP1[in_byte]) begin
                            rec_d.has_modrm = 1'b1;
                            state_d         = S_MODRM;
                        end else begin
                            done = 1'b1;
                        end
                    end
                end
                S_ESC: begin
                    rec_d.opcode = in_byte;
                    if (MODRM_MAP2[in_byte]) begin
                        rec_d.has_modrm = 1'b1;
                        state_d         = S_MODRM;
                    end else begin
                        done = 1'b1;
                    end
                end
                S_MODRM, S_SIB: begin
                    if (state_q == S_MODRM) begin
                        rec_d.modrm = in_byte;
                        dl = disp_len_f(in_byte[7:6], in_byte[2:0] == 3'b101);
                    end else begin
                        rec_d.sib = in_byte;
                        dl = disp_len_f(rec_q.modrm[7:6], in_byte[2:0] == 3'b101);
                    end
                    if (state_q == S_MODRM && in_byte[7:6] != 2'b11 && in_byte[2:0] == 3'b100) begin
                        rec_d.has_sib = 1'b1;
                        state_d       = S_SIB;
                    end else begin
                        rec_d.disp_len = dl;
                        if (dl != 3'd0) begin
                            disp_cnt_d = dl;
                            state_d    = S_DISP;
                        end else begin
                            done = 1'b1;
                        end
                    end
                end
                S_DISP: begin
                    // A lone disp8 is sign-extended; disp32 bytes shift in from the top, LSB first
                    if (rec_q.disp_len == 3'd1)
                        rec_d.disp = {{24{in_byte[7]}}, in_byte};
                    else
                        rec_d.disp = {in_byte, rec_q.disp[31:8]};
                    disp_cnt_d = disp_cnt_q - 3'd1;
                    if (disp_cnt_q == 3'd1)
                        done = 1'b1;
                end
                default: state_d = S_PFX;
            endcase
            if (done) begin
                out_d       = rec_d;
                out_valid_d = 1'b1;
                rec_d       = '0;
                state_d     = S_PFX;
                pfx_cnt_d   = 3'd0;
                disp_cnt_d  = 3'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_PFX;
            rec_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            pfx_cnt_q   <= 3'd0;
            disp_cnt_q  <= 3'd0;
        end else begin
            state_q     <= state_d;
            rec_q       <= rec_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            pfx_cnt_q   <= pfx_cnt_d;
            disp_cnt_q  <= disp_cnt_d;
        end
    end

    // Without X86_REX_EN the REX fields are never set, so these outputs stay 0
    assign out_valid     = out_valid_q;
    assign out_pfx       = out_q.pfx;
    assign out_seg_vld   = out_q.seg_vld;
    assign out_seg       = out_q.seg;
    assign out_rex_vld   = out_q.rex_vld;
    assign out_rex       = out_q.rex;
    assign out_esc       = out_q.esc;
    assign out_opcode    = out_q.opcode;
    assign out_has_modrm = out_q.has_modrm;
    assign out_modrm     = out_q.modrm;
    assign out_has_sib   = out_q.has_sib;
    assign out_sib       = out_q.sib;
    assign out_disp_len  = out_q.disp_len;
    assign out_disp      = out_q.disp;
    assign out_len       = out_q.len;
    assign out_err       = out_q.err;

endmodule
